// File: rtl/gp_engine_pkg.sv
// Shared types and constants for the GP engine command sequencer.
package gp_engine_pkg;

  // Opcode field location inside a command header word.
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 30;

  typedef enum logic [1:0] {
    OP_END   = 2'b00,
    OP_WRITE = 2'b01,
    OP_POLL  = 2'b10,
    OP_WAIT  = 2'b11
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_F0_REQ  = 3'd1,
    ST_F0_WAIT = 3'd2,
    ST_F1_REQ  = 3'd3,
    ST_F1_WAIT = 3'd4,
    ST_ISSUE   = 3'd5,
    ST_RESP    = 3'd6,
    ST_DELAY   = 3'd7
  } state_e;

endpackage

// File: rtl/gp_cmd_exec_fsm.sv
// Command-execution sequencer: fetches two-word commands from the command
// buffer and executes them as single master transactions until END.
//
// Handshakes:
//   - Command buffer: cmd_rd_en is a one-cycle request; the FSM then waits
//     for cmd_rd_valid and captures cmd_out in that cycle.
//   - Master request: mst_o_valid and all request fields stay stable until
//     the cycle in which mst_i_ready is high; the request is taken on that
//     edge. A read response is accepted only while in RESP, on mst_i_rd_valid.
module gp_cmd_exec_fsm
  import gp_engine_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 8,
  parameter int POLL_MAX   = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [PC_WIDTH-1:0]   start_pc,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [PC_WIDTH-1:0]   err_pc,
  output logic [DATA_WIDTH-1:0] last_rd_data,
  output logic                  cmd_rd_en,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_rd_valid,
  input  logic [DATA_WIDTH-1:0] cmd_out,
  output logic                  mst_o_valid,
  output logic [ADDR_WIDTH-1:0] mst_o_addr,
  output logic [DATA_WIDTH-1:0] mst_o_wr_data,
  output logic                  mst_o_rd0_wr1,
  input  logic                  mst_i_ready,
  input  logic                  mst_i_rd_valid,
  input  logic [DATA_WIDTH-1:0] mst_i_rd_data,
  output state_e                dbg_state
);

  state_e                state_q;
  logic [PC_WIDTH-1:0]   pc_q;
  logic [DATA_WIDTH-1:0] hdr_q;
  logic [DATA_WIDTH-1:0] operand_q;
  // Shared counter: poll attempts already made, or remaining delay cycles.
  logic [31:0]           cnt_q;

  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;
  logic [PC_WIDTH-1:0]   err_pc_q;
  logic [DATA_WIDTH-1:0] last_rd_data_q;
  logic                  cmd_rd_en_q;
  logic [ADDR_WIDTH-1:0] cmd_addr_q;
  logic                  mst_valid_q;
  logic [ADDR_WIDTH-1:0] mst_addr_q;
  logic [DATA_WIDTH-1:0] mst_wr_data_q;
  logic                  mst_wr_q;

  opcode_e               op;
  logic [31:0]           tgt_addr;
  logic [PC_WIDTH-1:0]   pc_plus1;
  logic [PC_WIDTH-1:0]   pc_plus2;
  logic [ADDR_WIDTH-1:0] start_pc_ext;
  logic [ADDR_WIDTH-1:0] pc_plus1_ext;
  logic [ADDR_WIDTH-1:0] pc_plus2_ext;
  logic [31:0]           poll_next;

  // Header decode and PC arithmetic; PC arithmetic wraps at 2^PC_WIDTH.
  assign op           = opcode_e'(hdr_q[OP_MSB:OP_LSB]);
  assign tgt_addr     = {hdr_q[OP_LSB-1:0], 2'b00};
  assign pc_plus1     = pc_q + PC_WIDTH'(1);
  assign pc_plus2     = pc_q + PC_WIDTH'(2);
  assign start_pc_ext = {{(ADDR_WIDTH-PC_WIDTH){1'b0}}, start_pc};
  assign pc_plus1_ext = {{(ADDR_WIDTH-PC_WIDTH){1'b0}}, pc_plus1};
  assign pc_plus2_ext = {{(ADDR_WIDTH-PC_WIDTH){1'b0}}, pc_plus2};
  assign poll_next    = cnt_q + 32'd1;

  // Sequencer FSM with registered outputs; next-command entry advances pc by 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      pc_q           <= '0;
      hdr_q          <= '0;
      operand_q      <= '0;
      cnt_q          <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      err_pc_q       <= '0;
      last_rd_data_q <= '0;
      cmd_rd_en_q    <= 1'b0;
      cmd_addr_q     <= '0;
      mst_valid_q    <= 1'b0;
      mst_addr_q     <= '0;
      mst_wr_data_q  <= '0;
      mst_wr_q       <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      cmd_rd_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_F0_REQ;
            pc_q        <= start_pc;
            cmd_addr_q  <= start_pc_ext;
            cmd_rd_en_q <= 1'b1;
            busy_q      <= 1'b1;
            err_q       <= 1'b0;
          end
        end
        ST_F0_REQ: state_q <= ST_F0_WAIT;
        ST_F0_WAIT: begin
          if (cmd_rd_valid) begin
            hdr_q       <= cmd_out;
            state_q     <= ST_F1_REQ;
            cmd_addr_q  <= pc_plus1_ext;
            cmd_rd_en_q <= 1'b1;
          end
        end
        ST_F1_REQ: state_q <= ST_F1_WAIT;
        ST_F1_WAIT: begin
          if (cmd_rd_valid) begin
            operand_q <= cmd_out;
            case (op)
              OP_END: begin
                state_q <= ST_IDLE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end
              OP_WRITE, OP_POLL: begin
                state_q       <= ST_ISSUE;
                mst_valid_q   <= 1'b1;
                mst_addr_q    <= ADDR_WIDTH'(tgt_addr);
                mst_wr_data_q <= cmd_out;
                mst_wr_q      <= (op == OP_WRITE);
                cnt_q         <= '0;
              end
              default: begin
                // WAIT with a zero operand costs no extra cycle.
                if (cmd_out == '0) begin
                  state_q     <= ST_F0_REQ;
                  pc_q        <= pc_plus2;
                  cmd_addr_q  <= pc_plus2_ext;
                  cmd_rd_en_q <= 1'b1;
                end else begin
                  state_q <= ST_DELAY;
                  cnt_q   <= 32'(cmd_out);
                end
              end
            endcase
          end
        end
        ST_ISSUE: begin
          if (mst_i_ready) begin
            mst_valid_q <= 1'b0;
            if (mst_wr_q) begin
              state_q     <= ST_F0_REQ;
              pc_q        <= pc_plus2;
              cmd_addr_q  <= pc_plus2_ext;
              cmd_rd_en_q <= 1'b1;
            end else begin
              state_q <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (mst_i_rd_valid) begin
            last_rd_data_q <= mst_i_rd_data;
            if (mst_i_rd_data == operand_q) begin
              state_q     <= ST_F0_REQ;
              pc_q        <= pc_plus2;
              cmd_addr_q  <= pc_plus2_ext;
              cmd_rd_en_q <= 1'b1;
            end else if (poll_next < 32'(POLL_MAX)) begin
              state_q     <= ST_ISSUE;
              cnt_q       <= poll_next;
              mst_valid_q <= 1'b1;
            end else begin
              state_q  <= ST_IDLE;
              err_q    <= 1'b1;
              err_pc_q <= pc_q;
              busy_q   <= 1'b0;
            end
          end
        end
        ST_DELAY: begin
          cnt_q <= cnt_q - 32'd1;
          if (cnt_q == 32'd1) begin
            state_q     <= ST_F0_REQ;
            pc_q        <= pc_plus2;
            cmd_addr_q  <= pc_plus2_ext;
            cmd_rd_en_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign err_pc        = err_pc_q;
  assign last_rd_data  = last_rd_data_q;
  assign cmd_rd_en     = cmd_rd_en_q;
  assign cmd_addr      = cmd_addr_q;
  assign mst_o_valid   = mst_valid_q;
  assign mst_o_addr    = mst_addr_q;
  assign mst_o_wr_data = mst_wr_data_q;
  assign mst_o_rd0_wr1 = mst_wr_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_gp_cmd_exec_fsm.sv
// Directed bench for gp_cmd_exec_fsm with a command-buffer model and a
// simple master responder.
module tb_gp_cmd_exec_fsm;
  import gp_engine_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int PW = 8;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start;
  logic [PW-1:0] start_pc;
  logic          busy, done, err;
  logic [PW-1:0] err_pc;
  logic [DW-1:0] last_rd_data;
  logic          cmd_rd_en;
  logic [AW-1:0] cmd_addr;
  logic          cmd_rd_valid = 1'b0;
  logic [DW-1:0] cmd_out = '0;
  logic          mst_o_valid;
  logic [AW-1:0] mst_o_addr;
  logic [DW-1:0] mst_o_wr_data;
  logic          mst_o_rd0_wr1;
  logic          mst_i_ready;
  logic          mst_i_rd_valid = 1'b0;
  logic [DW-1:0] mst_i_rd_data = '0;
  state_e        dbg_state;

  gp_cmd_exec_fsm #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PC_WIDTH(PW), .POLL_MAX(4)) dut (
    .clk(clk), .rst(rst), .start(start), .start_pc(start_pc),
    .busy(busy), .done(done), .err(err), .err_pc(err_pc),
    .last_rd_data(last_rd_data), .cmd_rd_en(cmd_rd_en), .cmd_addr(cmd_addr),
    .cmd_rd_valid(cmd_rd_valid), .cmd_out(cmd_out),
    .mst_o_valid(mst_o_valid), .mst_o_addr(mst_o_addr),
    .mst_o_wr_data(mst_o_wr_data), .mst_o_rd0_wr1(mst_o_rd0_wr1),
    .mst_i_ready(mst_i_ready), .mst_i_rd_valid(mst_i_rd_valid),
    .mst_i_rd_data(mst_i_rd_data), .dbg_state(dbg_state)
  );

  // Command buffer model: one-cycle read latency.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    cmd_rd_valid <= cmd_rd_en;
    if (cmd_rd_en) cmd_out <= mem[cmd_addr[7:0]];
  end

  // Master responder: read data one cycle after acceptance.
  logic [DW-1:0] resp_q[$];
  logic [DW-1:0] default_resp;
  int            wr_cnt, rd_cnt;
  logic [AW-1:0] last_wr_addr;
  logic [DW-1:0] last_wr_data;
  always @(posedge clk) begin
    mst_i_rd_valid <= 1'b0;
    if (!rst && mst_o_valid && mst_i_ready) begin
      if (mst_o_rd0_wr1) begin
        wr_cnt++;
        last_wr_addr = mst_o_addr;
        last_wr_data = mst_o_wr_data;
      end else begin
        rd_cnt++;
        mst_i_rd_valid <= 1'b1;
        mst_i_rd_data  <= (resp_q.size() > 0) ? resp_q.pop_front() : default_resp;
      end
    end
  end

  // Event monitor: timing relative to the accepted start edge.
  int            cyc = 0;
  int            start_cyc = 0;
  int            rd_en_rel[$];
  logic [AW-1:0] addr_log[$];
  int            first_valid_rel;
  int            done_rel;
  int            done_cnt;
  always @(posedge clk) begin
    if (cmd_rd_en) begin
      rd_en_rel.push_back(cyc - start_cyc);
      addr_log.push_back(cmd_addr);
    end
    if (mst_o_valid && first_valid_rel < 0) first_valid_rel = cyc - start_cyc;
    if (done) begin
      done_cnt++;
      done_rel = cyc - start_cyc;
    end
    if (start && !rst && dbg_state == ST_IDLE) start_cyc = cyc;
    cyc++;
  end

  // Scoreboard
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Driver tasks
  task automatic clear_logs();
    rd_en_rel.delete();
    addr_log.delete();
    resp_q.delete();
    first_valid_rel = -1;
    done_rel = -1;
    done_cnt = 0;
    wr_cnt = 0;
    rd_cnt = 0;
  endtask

  task automatic do_start(input logic [PW-1:0] pc);
    @(negedge clk);
    start = 1'b1;
    start_pc = pc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int max_cycles);
    bit seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (done || err) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, 64'(seen), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    start_pc = '0;
    mst_i_ready = 1'b1;
    default_resp = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    clear_logs();
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_err_pc", 64'(err_pc), 64'd0);
    chk("rst_last_rd", 64'(last_rd_data), 64'd0);
    chk("rst_cmd_rd_en", 64'(cmd_rd_en), 64'd0);
    chk("rst_cmd_addr", 64'(cmd_addr), 64'd0);
    chk("rst_mst_valid", 64'(mst_o_valid), 64'd0);
    chk("rst_mst_addr", 64'(mst_o_addr), 64'd0);
    chk("rst_mst_wdata", 64'(mst_o_wr_data), 64'd0);
    chk("rst_mst_wr", 64'(mst_o_rd0_wr1), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk);

    // WRITE then END
    mem[0] = 32'h4000_0004; mem[1] = 32'hDEAD_BEEF; mem[2] = 32'h0; mem[3] = 32'h0;
    clear_logs();
    do_start(8'd0);
    wait_end("wr_end_timeout", 100);
    chk("wr_count", 64'(wr_cnt), 64'd1);
    chk("wr_addr", 64'(last_wr_addr), 64'h10);
    chk("wr_data", 64'(last_wr_data), 64'hDEAD_BEEF);
    chk("wr_done_cycles", 64'(done_cnt), 64'd1);
    chk("wr_err", 64'(err), 64'd0);
    chk("wr_busy_after", 64'(busy), 64'd0);
    chk("wr_rd_en_c1", 64'(rd_en_rel[0]), 64'd1);
    chk("wr_rd_en_c3", 64'(rd_en_rel[1]), 64'd3);
    chk("wr_valid_c5", 64'(first_valid_rel), 64'd5);
    chk("wr_next_fetch_c6", 64'(rd_en_rel[2]), 64'd6);
    chk("wr_done_c10", 64'(done_rel), 64'd10);

    // POLL matching on third read
    mem[8] = 32'h8000_0008; mem[9] = 32'd5; mem[10] = 32'h0; mem[11] = 32'h0;
    clear_logs();
    resp_q.push_back(32'd0); resp_q.push_back(32'd0); resp_q.push_back(32'd5);
    do_start(8'd8);
    wait_end("poll_ok_timeout", 100);
    chk("poll_ok_reads", 64'(rd_cnt), 64'd3);
    chk("poll_ok_last_rd", 64'(last_rd_data), 64'd5);
    chk("poll_ok_err", 64'(err), 64'd0);
    chk("poll_ok_done", 64'(done_cnt), 64'd1);

    // POLL timeout after POLL_MAX=4 reads
    mem[20] = 32'h8000_0010; mem[21] = 32'h1234; mem[22] = 32'h0; mem[23] = 32'h0;
    clear_logs();
    default_resp = 32'h0;
    do_start(8'd20);
    wait_end("poll_to_timeout", 100);
    chk("poll_to_reads", 64'(rd_cnt), 64'd4);
    chk("poll_to_err", 64'(err), 64'd1);
    chk("poll_to_err_pc", 64'(err_pc), 64'd20);
    chk("poll_to_busy", 64'(busy), 64'd0);
    chk("poll_to_no_done", 64'(done_cnt), 64'd0);
    repeat (3) @(negedge clk);
    chk("poll_to_err_sticky", 64'(err), 64'd1);

    // WAIT D=0 then WRITE
    mem[30] = 32'hC000_0000; mem[31] = 32'd0; mem[32] = 32'h4000_0008;
    mem[33] = 32'hA5; mem[34] = 32'h0; mem[35] = 32'h0;
    clear_logs();
    do_start(8'd30);
    chk("wait0_err_cleared", 64'(err), 64'd0);
    wait_end("wait0_timeout", 100);
    chk("wait0_valid_c9", 64'(first_valid_rel), 64'd9);
    chk("wait0_wr_data", 64'(last_wr_data), 64'hA5);

    // WAIT D=10 then WRITE: write appears 10 cycles later
    mem[31] = 32'd10;
    clear_logs();
    do_start(8'd30);
    wait_end("wait10_timeout", 100);
    chk("wait10_valid_c19", 64'(first_valid_rel), 64'd19);
    chk("wait10_done", 64'(done_cnt), 64'd1);

    // PC wrap from 254
    mem[254] = 32'h4000_0003; mem[255] = 32'h77; mem[0] = 32'h0; mem[1] = 32'h0;
    clear_logs();
    exp_q.delete();
    exp_q.push_back(32'd254); exp_q.push_back(32'd255);
    exp_q.push_back(32'd0); exp_q.push_back(32'd1);
    do_start(8'd254);
    wait_end("wrap_timeout", 100);
    chk("wrap_addr_count", 64'(addr_log.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("wrap_cmd_addr_%0d", i), 64'(addr_log[i]), 64'(exp_q[i]));
    chk("wrap_wr_addr", 64'(last_wr_addr), 64'hC);
    chk("wrap_wr_data", 64'(last_wr_data), 64'h77);

    // Ready held low for 3 cycles; start while busy is ignored
    mem[40] = 32'h4000_0020; mem[41] = 32'hCAFE; mem[42] = 32'h0; mem[43] = 32'h0;
    clear_logs();
    mst_i_ready = 1'b0;
    do_start(8'd40);
    begin
      bit seen_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (mst_o_valid) begin
          seen_valid = 1'b1;
          break;
        end
        @(negedge clk);
      end
      chk("stall_valid_seen", 64'(seen_valid), 64'd1);
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stall_valid_%0d", i), 64'(mst_o_valid), 64'd1);
      chk($sformatf("stall_addr_%0d", i), 64'(mst_o_addr), 64'h80);
      chk($sformatf("stall_wdata_%0d", i), 64'(mst_o_wr_data), 64'hCAFE);
      chk($sformatf("stall_wr_%0d", i), 64'(mst_o_rd0_wr1), 64'd1);
      start = (i == 0);
      start_pc = 8'd100;
      @(negedge clk);
    end
    start = 1'b0;
    mst_i_ready = 1'b1;
    wait_end("stall_timeout", 100);
    chk("stall_wr_count", 64'(wr_cnt), 64'd1);
    chk("busy_start_ignored_a2", 64'(addr_log[2]), 64'd42);
    chk("busy_start_ignored_a3", 64'(addr_log[3]), 64'd43);
    chk("stall_done", 64'(done_cnt), 64'd1);

    // Reset mid-DELAY
    mem[50] = 32'hC000_0000; mem[51] = 32'd100;
    clear_logs();
    do_start(8'd50);
    begin
      bit seen_delay = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (dbg_state == ST_DELAY) begin
          seen_delay = 1'b1;
          break;
        end
      end
      chk("delay_reached", 64'(seen_delay), 64'd1);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("mid_rst_cmd_addr", 64'(cmd_addr), 64'd0);
    chk("mid_rst_last_rd", 64'(last_rd_data), 64'd0);
    chk("mid_rst_mst_valid", 64'(mst_o_valid), 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", 64'(dbg_state), 64'(ST_IDLE));
    chk("post_rst_rd_en", 64'(cmd_rd_en), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gp_cmd_exec_fsm.md
# gp_cmd_exec_fsm

Command-execution sequencer of the GP engine, directly downstream of the command buffer. On `start` it fetches two-word commands from the command buffer's FSM read port and executes them as single register transactions on the engine's AHB-master request interface. It runs until an END command, and reports `done` or `err`.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: master address width and `cmd_addr` width.
- `DATA_WIDTH`, 32: master data width; command word width.
- `PC_WIDTH`, 8: command-buffer word index width (256 words).
- `POLL_MAX`, 1024: maximum read attempts per POLL; must be ≥ 1.

Ports (the clock is `clk`; reset `rst` is synchronous and active-high):
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  single-cycle start pulse.
- `start_pc`  in  PC_WIDTH  word index of the first command.
- `busy`  out  1  high from the cycle after an accepted start until `done`/`err`.
- `done`  out  1  one-cycle pulse when END executes.
- `err`  out  1  sticky; cleared by the next accepted `start`.
- `err_pc`  out  PC_WIDTH  header index of the failing command.
- `last_rd_data`  out  DATA_WIDTH  data of the most recent master read.
- `cmd_rd_en`  out  1  command-buffer read request.
- `cmd_addr`  out  ADDR_WIDTH  word index, zero-extended from the PC.
- `cmd_rd_valid`  in  1  buffer read data valid.
- `cmd_out`  in  DATA_WIDTH  buffer read data.
- `mst_o_valid`  out  1  master request valid.
- `mst_o_addr`  out  ADDR_WIDTH  target address.
- `mst_o_wr_data`  out  DATA_WIDTH  write data.
- `mst_o_rd0_wr1`  out  1  1 = write.
- `mst_i_ready`  in  1  master accepts the request.
- `mst_i_rd_valid`  in  1  read response valid.
- `mst_i_rd_data`  in  DATA_WIDTH  read response data.

## Operation
Command format. Each command is two words: a header H at index `pc` and an operand D at index `pc+1`. Both are fetched before execution, whatever the opcode.
- H[31:30] is the opcode and H[29:0] is the word address; the target address is `{H[29:0],2'b00}`.
- Opcode 00, END: pulse `done` and go to IDLE.
- Opcode 01, WRITE: one master write of D to the target address.
- Opcode 10, POLL: repeated master reads of the target address until the read data equals D. After `POLL_MAX` reads with no match, set `err`, set `err_pc` to the header index, and go to IDLE.
- Opcode 11, WAIT: idle for D cycles. D = 0 means no extra cycles.

After a command completes, `pc` advances by 2, modulo 2^PC_WIDTH. Wrap is legal: a header at 255 takes its operand from index 0.

States:
- IDLE
- F0_REQ, F0_WAIT: fetch H.
- F1_REQ, F1_WAIT: fetch D.
- ISSUE
- RESP
- DELAY

Transitions:
- IDLE → F0_REQ on `start`. This clears `err` and sets `pc` to `start_pc`. `start` is ignored while `busy`.
- *_REQ: drive `cmd_rd_en` = 1 for exactly one cycle, then move to *_WAIT.
- *_WAIT: hold `cmd_rd_en` = 0 until `cmd_rd_valid` is high, then capture `cmd_out`.
- F1_WAIT routes by opcode: END → IDLE; WRITE and POLL → ISSUE; WAIT → DELAY.
- ISSUE: hold `mst_o_valid`, `mst_o_addr`, `mst_o_wr_data` and `mst_o_rd0_wr1` stable until `mst_i_ready` is high in the same cycle. A WRITE then goes to F0_REQ; a POLL goes to RESP.
- RESP: wait for `mst_i_rd_valid`, then load `last_rd_data`. On a match, go to F0_REQ. On a mismatch with fewer than `POLL_MAX` attempts, go back to ISSUE. Otherwise, error.
- DELAY: decrement the 32-bit counter, then go to F0_REQ when it reaches 0.

## Timing
- Reset values: all outputs are 0, the state is IDLE, and `pc` is 0.
- Reset mid-operation takes effect at the next edge: `mst_o_valid` drops and any outstanding master response is ignored.
- Each fetch takes 2 cycles when the buffer responds in one cycle.
- WRITE, with `start` at edge 0 and `mst_i_ready` held high:
  - `cmd_rd_en` is high in cycles 1 and 3.
  - `mst_o_valid` is high in cycle 5.
  - The next header fetch starts in cycle 6.
- WAIT D adds D cycles to the fetch time.
- `done` and the `err` set both occur in the cycle following the deciding capture or response.
- `busy` falls in the same cycle that `done` is high or `err` is set.
- An `mst_i_rd_valid` seen outside RESP is ignored.

## Structure
- Package `gp_engine_pkg` holds:
  - the opcode enum (END, WRITE, POLL, WAIT);
  - the state enum;
  - the constants `OP_MSB`=31 and `OP_LSB`=30.
- The block is a single module; no sub-module is needed. The poll counter and the delay counter may share one register.

## Test plan
- WRITE then END: buffer[0]=0x4000_0004, [1]=0xDEAD_BEEF, [2]=0 → one write of 0xDEADBEEF to 0x0000_0010; `done` pulses 1 cycle.
- POLL matching on the 3rd read: responses 0, 0, 5 with D=5 → 3 master reads, `last_rd_data`=5, `err`=0, then `done`.
- POLL timeout with `POLL_MAX`=4 and data never matching → exactly 4 reads, `err`=1, `err_pc`=`start_pc`, `busy`=0, no `done`.
- WAIT D=10 followed by WRITE → the write's `mst_o_valid` appears 10 cycles later than with D=0.
- Wrap with `start_pc`=254: [254]=WRITE header, [255]=data, [0]=END → `cmd_addr` sequence 254, 255, 0, 1.
- `mst_i_ready` low for 3 cycles → request fields stay stable; `rst` asserted mid-DELAY → outputs return to reset values next cycle; a `start` while `busy` is ignored.
